mem_port_arbiter: RTL and testbench

- Shares one single-ported backing memory bus between the instruction-fetch port and the data (load/store) port of the 5-stage pipeline.
- Sits between the fetch/mem stages and the memory model. It presents the same fe_* and mem_* handshakes the stages already use, so the memory model becomes single-ported.
- Data port has priority. A starvation counter guarantees fetch progress.
- Every granted transaction runs to completion.

---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/mem_port_arbiter_starve_counter.sv | 37 +++
 rtl/mem_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared encodings for the fetch/data memory port arbiter:
//   access width codes, arbiter FSM states and bus owner codes.
package mem_port_arbiter_pkg;

  localparam logic [1:0] MEM_W_BYTE = 2'b00;
  localparam logic [1:0] MEM_W_HALF = 2'b01;
  localparam logic [1:0] MEM_W_WORD = 2'b10;

  localparam int STARVE_W   = 4;
  localparam int STARVE_MAX = (1 << STARVE_W) - 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY_FE  = 2'd1,
    ST_BUSY_MEM = 2'd2,
    ST_RESP     = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_FE   = 2'd1,
    OWN_MEM  = 2'd2
  } arb_owner_e;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// arb_starve_counter
//   Counts data grants made while fetch is waiting. Saturates at 15.
//   Ports:
//     clk, reset_n  clock, async active-low reset
//     inc           count one data grant that bypassed a waiting fetch
//     clr           clear (takes priority over inc)
//     at_limit      count >= LIMIT, fetch must win the next contest
module arb_starve_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  logic [STARVE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != STARVE_W'(STARVE_MAX)))
      cnt_d = cnt_q + STARVE_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign at_limit = (cnt_q >= STARVE_W'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported backing memory bus between the fetch port
//   (fe_*) and the load/store port (mem_*). Data port wins contests unless
//   fetch has been bypassed FE_STARVE_LIMIT times in a row. One transaction
//   is outstanding at a time and always runs to completion.
//   Ports:
//     clk, reset_n            clock, async active-low reset
//     fe_req/fe_addr          fetch request (held until fe_ack)
//     fe_ack/fe_data          one-cycle completion pulse + fetched word
//     mem_req/addr/write/...  data request (held until mem_ack)
//     mem_ack/mem_data_out    one-cycle completion pulse + load data
//     bus_*                   registered request to the backing memory
//     bus_ack/bus_rdata       backing memory completion + read data
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int FE_STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fe_req,
  input  logic [ADDR_WIDTH-1:0] fe_addr,
  output logic                  fe_ack,
  output logic [DATA_WIDTH-1:0] fe_data,
  input  logic                  mem_req,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic                  mem_extend,
  input  logic [1:0]            mem_width,
  output logic                  mem_ack,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  bus_req,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic                  bus_write,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic                  bus_extend,
  output logic [1:0]            bus_width,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_rdata
);

  arb_state_e            state_q, state_d;
  arb_owner_e            owner_q, owner_d;
  logic                  bus_req_q, bus_req_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic                  bus_write_q, bus_write_d;
  logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic                  bus_extend_q, bus_extend_d;
  logic [1:0]            bus_width_q, bus_width_d;
  logic                  fe_ack_q, fe_ack_d;
  logic                  mem_ack_q, mem_ack_d;
  logic [DATA_WIDTH-1:0] fe_data_q, fe_data_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic                  starve_inc, starve_clr, starve_hit;

  arb_starve_counter #(.LIMIT(FE_STARVE_LIMIT)) u_starve (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc      (starve_inc),
    .clr      (starve_clr),
    .at_limit (starve_hit)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    bus_req_d    = bus_req_q;
    bus_addr_d   = bus_addr_q;
    bus_write_d  = bus_write_q;
    bus_wdata_d  = bus_wdata_q;
    bus_extend_d = bus_extend_q;
    bus_width_d  = bus_width_q;
    fe_data_d    = fe_data_q;
    mem_data_d   = mem_data_q;
    fe_ack_d     = 1'b0;
    mem_ack_d    = 1'b0;
    starve_inc   = 1'b0;
    starve_clr   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Fetch not waiting: no starvation history to keep.
        starve_clr = !fe_req;
        if (fe_req && (!mem_req || starve_hit)) begin
          state_d      = ST_BUSY_FE;
          owner_d      = OWN_FE;
          bus_req_d    = 1'b1;
          bus_addr_d   = fe_addr;
          bus_write_d  = 1'b0;
          bus_wdata_d  = '0;
          bus_extend_d = 1'b0;
          bus_width_d  = MEM_W_WORD;
          starve_clr   = 1'b1;
        end else if (mem_req) begin
          state_d      = ST_BUSY_MEM;
          owner_d      = OWN_MEM;
          bus_req_d    = 1'b1;
          bus_addr_d   = mem_addr;
          bus_write_d  = mem_write;
          bus_wdata_d  = mem_data_in;
          bus_extend_d = mem_extend;
          bus_width_d  = mem_width;
          starve_inc   = fe_req;
        end
      end
      ST_BUSY_FE, ST_BUSY_MEM: begin
        if (bus_ack) begin
          state_d   = ST_RESP;
          bus_req_d = 1'b0;
          if (owner_q == OWN_FE) begin
            fe_data_d = bus_rdata;
            fe_ack_d  = 1'b1;
          end else begin
            mem_data_d = bus_rdata;
            mem_ack_d  = 1'b1;
          end
        end
      end
      // Requester still holds req while its ack is visible, so no grant here.
      ST_RESP: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d   = ST_IDLE;
        owner_d   = OWN_NONE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_NONE;
      bus_req_q    <= 1'b0;
      bus_addr_q   <= '0;
      bus_write_q  <= 1'b0;
      bus_wdata_q  <= '0;
      bus_extend_q <= 1'b0;
      bus_width_q  <= 2'b00;
      fe_ack_q     <= 1'b0;
      mem_ack_q    <= 1'b0;
      fe_data_q    <= '0;
      mem_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      bus_req_q    <= bus_req_d;
      bus_addr_q   <= bus_addr_d;
      bus_write_q  <= bus_write_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_extend_q <= bus_extend_d;
      bus_width_q  <= bus_width_d;
      fe_ack_q     <= fe_ack_d;
      mem_ack_q    <= mem_ack_d;
      fe_data_q    <= fe_data_d;
      mem_data_q   <= mem_data_d;
    end
  end

  assign bus_req      = bus_req_q;
  assign bus_addr     = bus_addr_q;
  assign bus_write    = bus_write_q;
  assign bus_wdata    = bus_wdata_q;
  assign bus_extend   = bus_extend_q;
  assign bus_width    = bus_width_q;
  assign fe_ack       = fe_ack_q;
  assign mem_ack      = mem_ack_q;
  assign fe_data      = fe_data_q;
  assign mem_data_out = mem_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Requester and memory agents drive the arbiter from transaction queues;
//   a transaction-level model predicts every output each cycle.
module tb_mem_port_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fe_req, fe_ack, mem_req, mem_ack;
  logic [31:0] fe_addr, fe_data, mem_addr, mem_data_in, mem_data_out;
  logic        mem_write, mem_extend;
  logic [1:0]  mem_width;
  logic        bus_req, bus_write, bus_extend, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [1:0]  bus_width;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FE_STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset_n(reset_n),
    .fe_req(fe_req), .fe_addr(fe_addr), .fe_ack(fe_ack), .fe_data(fe_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_write(mem_write),
    .mem_data_in(mem_data_in), .mem_extend(mem_extend), .mem_width(mem_width),
    .mem_ack(mem_ack), .mem_data_out(mem_data_out),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_write(bus_write),
    .bus_wdata(bus_wdata), .bus_extend(bus_extend), .bus_width(bus_width),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  typedef struct {logic [31:0] addr; int gap;} fe_txn_t;
  typedef struct {logic [31:0] addr; logic wr; logic [31:0] wd; logic ext; logic [1:0] w; int gap;} mem_txn_t;

  fe_txn_t  fe_q[$];
  mem_txn_t mem_q[$];
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory agent ----------------
  int          wait_cfg = 0, wait_max = 0, rcnt = -1;
  bit          rd_rand = 0, spurious = 0;
  logic [31:0] rd_fixed = 32'h0;
  initial begin
    bus_ack = 1'b0; bus_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      bus_ack = 1'b0;
      if (!reset_n) rcnt = -1;
      else if (bus_req) begin
        if (rcnt < 0) rcnt = rd_rand ? int'($urandom_range(wait_max)) : wait_cfg;
        if (rcnt == 0) begin
          bus_ack = 1'b1;
          bus_rdata = rd_rand ? $urandom : rd_fixed;
          rcnt = -1;
        end else rcnt--;
      end else begin
        rcnt = -1;
        if (spurious) begin bus_ack = 1'b1; bus_rdata = 32'hBAD0BAD0; end
      end
    end
  end

  // ---------------- fetch requester ----------------
  bit fe_act = 0, fe_got = 0;
  int fe_gap = 0, fe_cur_gap = 0;
  initial begin
    fe_txn_t ft;
    fe_req = 1'b0; fe_addr = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (!reset_n) begin fe_req = 1'b0; fe_act = 0; fe_got = 0; fe_gap = 0; end
      else begin
        if (fe_act && fe_got) begin fe_act = 0; fe_got = 0; fe_req = 1'b0; fe_gap = fe_cur_gap; end
        else if (fe_act && fe_ack) fe_got = 1;
        if (!fe_act) begin
          if (fe_gap > 0) fe_gap--;
          else if (fe_q.size() > 0) begin
            ft = fe_q.pop_front();
            fe_addr = ft.addr; fe_req = 1'b1; fe_act = 1; fe_cur_gap = ft.gap;
          end
        end
      end
    end
  end

  // ---------------- data requester ----------------
  bit mem_act = 0, mem_got = 0;
  int mem_gap = 0, mem_cur_gap = 0;
  initial begin
    mem_txn_t mt;
    mem_req = 1'b0; mem_addr = 32'h0; mem_write = 1'b0; mem_data_in = 32'h0;
    mem_extend = 1'b0; mem_width = 2'b00;
    forever begin
      @(posedge clk); #1;
      if (!reset_n) begin mem_req = 1'b0; mem_act = 0; mem_got = 0; mem_gap = 0; end
      else begin
        if (mem_act && mem_got) begin mem_act = 0; mem_got = 0; mem_req = 1'b0; mem_gap = mem_cur_gap; end
        else if (mem_act && mem_ack) mem_got = 1;
        if (!mem_act) begin
          if (mem_gap > 0) mem_gap--;
          else if (mem_q.size() > 0) begin
            mt = mem_q.pop_front();
            mem_addr = mt.addr; mem_write = mt.wr; mem_data_in = mt.wd;
            mem_extend = mt.ext; mem_width = mt.w; mem_req = 1'b1; mem_act = 1;
            mem_cur_gap = mt.gap;
          end
        end
      end
    end
  end

  // ---------------- transaction-level model ----------------
  // m_out: owner of the transaction on the bus (0 none, 1 fetch, 2 data)
  // m_ack: owner whose ack is visible this cycle
  int          m_out = 0, m_ack = 0, m_starve = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_fe_data = 0, m_mem_data = 0;
  logic        m_write = 0, m_ext = 0;
  logic [1:0]  m_width = 0;
  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_out = 0; m_ack = 0; m_starve = 0; m_addr = 0; m_wdata = 0;
        m_fe_data = 0; m_mem_data = 0; m_write = 0; m_ext = 0; m_width = 0;
      end else if (m_out != 0) begin
        if (bus_ack) begin
          if (m_out == 1) m_fe_data = bus_rdata; else m_mem_data = bus_rdata;
          m_ack = m_out; m_out = 0;
        end
      end else if (m_ack != 0) begin
        m_ack = 0;
      end else if (fe_req && (!mem_req || m_starve >= LIM)) begin
        m_out = 1; m_starve = 0;
        m_addr = fe_addr; m_write = 0; m_wdata = 0; m_ext = 0; m_width = 2'b10;
      end else if (mem_req) begin
        m_out = 2;
        m_starve = fe_req ? ((m_starve >= 15) ? 15 : m_starve + 1) : 0;
        m_addr = mem_addr; m_write = mem_write; m_wdata = mem_data_in;
        m_ext = mem_extend; m_width = mem_width;
      end else m_starve = 0;
    end
  end

  // ---------------- compare + monitor ----------------
  int          fe_acks = 0, mem_acks = 0, burst = 0, last_burst = 0;
  int          ack_log[$];
  logic [31:0] fe_last = 0, mem_last = 0, snap_addr = 0, snap_wd = 0, snap_ctl = 0;
  logic        prev_req = 0;
  initial begin
    forever begin
      @(negedge clk);
      chk("bus_req",  bus_req,    (m_out != 0));
      chk("bus_addr", bus_addr,   m_addr);
      chk("bus_wr",   bus_write,  m_write);
      chk("bus_wd",   bus_wdata,  m_wdata);
      chk("bus_ext",  bus_extend, m_ext);
      chk("bus_w",    bus_width,  m_width);
      chk("fe_ack",   fe_ack,     (m_ack == 1));
      chk("mem_ack",  mem_ack,    (m_ack == 2));
      chk("fe_data",  fe_data,    m_fe_data);
      chk("mem_dout", mem_data_out, m_mem_data);
      if (fe_ack)  begin fe_acks++;  ack_log.push_back(1); fe_last  = fe_data; end
      if (mem_ack) begin mem_acks++; ack_log.push_back(2); mem_last = mem_data_out; end
      if (bus_req && !prev_req) begin
        snap_addr = bus_addr; snap_wd = bus_wdata;
        snap_ctl = {28'h0, bus_write, bus_extend, bus_width};
        burst = 1;
      end else if (bus_req) begin
        burst++;
        chk("hold_addr", bus_addr, snap_addr);
        chk("hold_wd",   bus_wdata, snap_wd);
        chk("hold_ctl",  {28'h0, bus_write, bus_extend, bus_width}, snap_ctl);
      end
      if (!bus_req && prev_req) last_burst = burst;
      prev_req = bus_req;
    end
  end

  function automatic int log_at(input int i);
    return (i < ack_log.size()) ? ack_log[i] : -1;
  endfunction

  task automatic wait_idle(input int limit);
    int n = 0;
    do begin
      @(negedge clk); n++;
    end while (!(fe_q.size() == 0 && mem_q.size() == 0 && !fe_act && !mem_act &&
                 !bus_req && !fe_ack && !mem_ack) && n < limit);
    if (n >= limit) chk("drain_timeout", 32'(n), 32'(limit - 1));
  endtask

  int f0, m0, l0, n;
  int exp_seq[6] = '{2, 2, 2, 2, 1, 2};

  initial begin
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_fe_ack", fe_ack, 0);
    chk("rst_mem_ack", mem_ack, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_fe_data", fe_data, 0);
    chk("rst_mem_dout", mem_data_out, 0);
    @(posedge clk); #3 reset_n = 1'b1;

    // fetch only
    rd_fixed = 32'h00000013; wait_cfg = 0;
    f0 = fe_acks; m0 = mem_acks;
    fe_q.push_back('{addr: 32'h100, gap: 0});
    wait_idle(100);
    chk("t1_addr", snap_addr, 32'h100);
    chk("t1_ctl", snap_ctl, 32'h2);
    chk("t1_fe_acks", fe_acks - f0, 1);
    chk("t1_fe_data", fe_last, 32'h13);
    chk("t1_mem_acks", mem_acks - m0, 0);
    chk("t1_burst", last_burst, 1);

    // simultaneous: data first
    rd_fixed = 32'h0000CAFE; l0 = ack_log.size();
    mem_q.push_back('{addr: 32'h200, wr: 1'b1, wd: 32'hDEADBEEF, ext: 1'b0, w: 2'b10, gap: 0});
    fe_q.push_back('{addr: 32'h104, gap: 0});
    wait_idle(100);
    chk("t2_first", log_at(l0), 2);
    chk("t2_second", log_at(l0 + 1), 1);
    chk("t2_store_dout", mem_last, 32'hCAFE);

    // starvation
    l0 = ack_log.size();
    for (int i = 0; i < 5; i++)
      mem_q.push_back('{addr: 32'h300 + 32'(4 * i), wr: 1'b0, wd: 32'h0, ext: 1'b0, w: 2'b10, gap: 0});
    fe_q.push_back('{addr: 32'h108, gap: 0});
    wait_idle(200);
    for (int i = 0; i < 6; i++) chk($sformatf("t3_seq%0d", i), log_at(l0 + i), exp_seq[i]);
    chk("t3_starve_clr", dut.u_starve.cnt_q, 0);

    // wait states on a sign-extended byte load
    wait_cfg = 5; rd_fixed = 32'h00000080; m0 = mem_acks;
    mem_q.push_back('{addr: 32'h203, wr: 1'b0, wd: 32'h0, ext: 1'b1, w: 2'b00, gap: 0});
    wait_idle(100);
    chk("t4_burst", last_burst, 6);
    chk("t4_addr", snap_addr, 32'h203);
    chk("t4_ctl", snap_ctl, 32'h4);
    chk("t4_dout", mem_last, 32'h80);
    chk("t4_mem_acks", mem_acks - m0, 1);

    // reset mid data transaction
    wait_cfg = 20; m0 = mem_acks;
    mem_q.push_back('{addr: 32'h400, wr: 1'b0, wd: 32'h0, ext: 1'b0, w: 2'b10, gap: 0});
    n = 0;
    while (!bus_req && n < 20) begin @(negedge clk); n++; end
    chk("t5_granted", bus_req, 1);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    #1 chk("t5_async_drop", bus_req, 0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1; wait_cfg = 0;
    repeat (30) @(negedge clk);
    chk("t5_no_ack", mem_acks - m0, 0);
    f0 = fe_acks;
    fe_q.push_back('{addr: 32'h10C, gap: 0});
    wait_idle(100);
    chk("t5_fe_after", fe_acks - f0, 1);

    // spurious bus_ack while idle
    f0 = fe_acks; m0 = mem_acks;
    @(posedge clk); #3 spurious = 1;
    @(posedge clk); #3 spurious = 0;
    repeat (3) @(negedge clk);
    chk("t6_fe_acks", fe_acks - f0, 0);
    chk("t6_mem_acks", mem_acks - m0, 0);
    chk("t6_bus_req", bus_req, 0);

    // randomized traffic
    rd_rand = 1; wait_max = 3;
    for (int i = 0; i < 60; i++) begin
      fe_q.push_back('{addr: $urandom, gap: int'($urandom_range(3))});
      mem_q.push_back('{addr: $urandom, wr: 1'($urandom), wd: $urandom, ext: 1'($urandom),
                        w: 2'($urandom_range(2)), gap: int'($urandom_range(2))});
    end
    wait_idle(20000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
